// File: rtl/input_tile_mem.sv
// -----------------------------------------------------------------------------
// input_tile_mem
//
// Responder side of the input-tile memory used by the Winograd input data
// controller. Each 512-bit line holds one raw 6x6 int8 input tile. An external
// loader fills lines with bursts of 64-bit beats (first beat = line MSBs); two
// independent read ports return whole lines one cycle after a request.
//
// FSM states
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | waiting for load_start_i; reads are still served
//   LOAD  | accepting beats, writing one line every BEATS accepted beats
//   DONE  | single-cycle load_done_o pulse, then back to IDLE
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   load_start_i               begin a burst (sampled in IDLE only)
//   load_base_i, load_lines_i  first line and line count (0 = no-op)
//   load_valid_i, load_data_i  beat handshake and payload
//   load_ready_o               beat accept, high for the whole LOAD state
//   load_done_o                one-cycle pulse after the last line is written
//   busy_o                     high while not IDLE
//   input_addr_i_1/2           read addresses
//   input_request_i            read request for both ports
//   input_data_o_1/2           read data, valid one cycle after the request
//   input_valid_o              read data valid
//
// Line 0xFF is a sentinel: writes to it are dropped and reads return zero.
// Memory contents survive reset.
// -----------------------------------------------------------------------------
module input_tile_mem #(
  parameter int DEPTH  = 256,
  parameter int LINE_W = 512,
  parameter int BEAT_W = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_start_i,
  input  logic [7:0]               load_base_i,
  input  logic [7:0]               load_lines_i,
  input  logic                     load_valid_i,
  input  logic [BEAT_W-1:0]        load_data_i,
  output logic                     load_ready_o,
  output logic                     load_done_o,
  output logic                     busy_o,
  input  logic [7:0]               input_addr_i_1,
  input  logic [7:0]               input_addr_i_2,
  input  logic                     input_request_i,
  output logic signed [LINE_W-1:0] input_data_o_1,
  output logic signed [LINE_W-1:0] input_data_o_2,
  output logic                     input_valid_o
);

  localparam int BEATS = LINE_W / BEAT_W;
  localparam int BCW   = $clog2(BEATS);
  localparam logic [7:0] SENTINEL = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [BCW-1:0]    beat_cnt;
  logic [7:0]        line_addr;
  logic [7:0]        lines_left;
  logic [LINE_W-1:0] line_buf;
  logic [LINE_W-1:0] wr_line;
  logic [LINE_W-1:0] mem [DEPTH];

  logic beat_acc;
  logic last_beat;
  logic wr_en;

  // Handshake outputs are decoded straight from the state register.
  assign load_ready_o = (state == LOAD);
  assign load_done_o  = (state == DONE);
  assign busy_o       = (state != IDLE);

  assign beat_acc  = load_ready_o && load_valid_i;
  assign last_beat = beat_acc && (beat_cnt == BCW'(BEATS - 1));
  // A reset on the same edge as the final beat aborts that line too.
  assign wr_en     = last_beat && !reset && (line_addr != SENTINEL);

  // The final beat lands in the LSB slot; merge it in the write cycle so the
  // line is stored without an extra assembly cycle.
  always_comb begin
    wr_line = line_buf;
    wr_line[BEAT_W-1:0] = load_data_i;
  end

  // Control FSM and burst counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      line_addr  <= '0;
      lines_left <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_start_i && (load_lines_i != 8'd0)) begin
            state      <= LOAD;
            line_addr  <= load_base_i;
            lines_left <= load_lines_i;
            beat_cnt   <= '0;
          end
        end
        LOAD: begin
          if (beat_acc) begin
            if (last_beat) begin
              beat_cnt   <= '0;
              line_addr  <= line_addr + 8'd1;
              lines_left <= lines_left - 8'd1;
              if (lines_left == 8'd1) begin
                state <= DONE;
              end
            end else begin
              beat_cnt <= beat_cnt + BCW'(1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Line assembly: beat k goes to slot k counted from the MSB end. The buffer
  // needs no reset because every line is fully rewritten before use.
  always_ff @(posedge clk) begin
    if (beat_acc) begin
      for (int k = 0; k < BEATS; k++) begin
        if (beat_cnt == BCW'(k)) begin
          line_buf[LINE_W-1-BEAT_W*k -: BEAT_W] <= load_data_i;
        end
      end
    end
  end

  // Storage array; deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[line_addr] <= wr_line;
    end
  end

  // Dual read ports. The array read sees the pre-write contents, so a read and
  // write of the same line on one edge returns the old line.
  always_ff @(posedge clk) begin
    if (reset) begin
      input_valid_o  <= 1'b0;
      input_data_o_1 <= '0;
      input_data_o_2 <= '0;
    end else if (input_request_i) begin
      input_valid_o  <= 1'b1;
      input_data_o_1 <= (input_addr_i_1 == SENTINEL) ? '0 : mem[input_addr_i_1];
      input_data_o_2 <= (input_addr_i_2 == SENTINEL) ? '0 : mem[input_addr_i_2];
    end else begin
      input_valid_o  <= 1'b0;
      input_data_o_1 <= '0;
      input_data_o_2 <= '0;
    end
  end

endmodule

// File: tb/tb_input_tile_mem.sv
module tb_input_tile_mem;

  logic               clk = 1'b0;
  logic               reset;
  logic               load_start_i;
  logic [7:0]         load_base_i;
  logic [7:0]         load_lines_i;
  logic               load_valid_i;
  logic [63:0]        load_data_i;
  logic               load_ready_o;
  logic               load_done_o;
  logic               busy_o;
  logic [7:0]         input_addr_i_1;
  logic [7:0]         input_addr_i_2;
  logic               input_request_i;
  logic signed [511:0] input_data_o_1;
  logic signed [511:0] input_data_o_2;
  logic               input_valid_o;

  int vectors = 0;
  int errors  = 0;

  // Reference model: what each line should hold, and whether it was written.
  logic [511:0] exp_mem [256];
  bit           known   [256];

  input_tile_mem dut (
    .clk             (clk),
    .reset           (reset),
    .load_start_i    (load_start_i),
    .load_base_i     (load_base_i),
    .load_lines_i    (load_lines_i),
    .load_valid_i    (load_valid_i),
    .load_data_i     (load_data_i),
    .load_ready_o    (load_ready_o),
    .load_done_o     (load_done_o),
    .busy_o          (busy_o),
    .input_addr_i_1  (input_addr_i_1),
    .input_addr_i_2  (input_addr_i_2),
    .input_request_i (input_request_i),
    .input_data_o_1  (input_data_o_1),
    .input_data_o_2  (input_data_o_2),
    .input_valid_o   (input_valid_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] exp_rd(input logic [7:0] a);
    if (a == 8'hFF) return '0;
    return exp_mem[a];
  endfunction

  // gap_mode: 0 = continuous, 1 = random idle cycles, 2 = two idle cycles before beat 3
  // patt: 1 = beat k of line L is {8{L*8+k}}, 0 = random beats
  task automatic do_load(input logic [7:0] base, input logic [7:0] lines,
                         input int gap_mode, input bit patt);
    logic [511:0] line;
    logic [63:0]  beat;
    logic [7:0]   a;
    int           gaps;
    load_start_i = 1'b1;
    load_base_i  = base;
    load_lines_i = lines;
    step();
    load_start_i = 1'b0;
    a = base;
    for (int l = 0; l < int'(lines); l++) begin
      line = '0;
      for (int k = 0; k < 8; k++) begin
        gaps = (gap_mode == 1) ? int'($urandom_range(0, 2)) :
               (gap_mode == 2 && k == 3) ? 2 : 0;
        for (int g = 0; g < gaps; g++) begin
          load_valid_i = 1'b0;
          load_data_i  = {$urandom, $urandom};
          vectors++;
          if (load_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL load_ready_gap got %0b exp 1", load_ready_o);
          end
          step();
        end
        beat = patt ? {8{8'(l * 8 + k)}} : {$urandom, $urandom};
        line[511 - 64 * k -: 64] = beat;
        load_valid_i = 1'b1;
        load_data_i  = beat;
        vectors++;
        if (load_ready_o !== 1'b1 || load_done_o !== 1'b0 || busy_o !== 1'b1) begin
          errors++;
          $display("FAIL load_beat_hs got rdy=%0b done=%0b busy=%0b exp 1/0/1",
                   load_ready_o, load_done_o, busy_o);
        end
        step();
      end
      if (a != 8'hFF) begin
        exp_mem[a] = line;
        known[a]   = 1'b1;
      end
      a = a + 8'd1;
    end
    load_valid_i = 1'b0;
    vectors++;
    if (load_done_o !== 1'b1 || busy_o !== 1'b1 || load_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL load_done_pulse got done=%0b busy=%0b rdy=%0b exp 1/1/0",
               load_done_o, busy_o, load_ready_o);
    end
    step();
    vectors++;
    if (load_done_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL load_idle_after got done=%0b busy=%0b exp 0/0", load_done_o, busy_o);
    end
  endtask

  // One request cycle; leaves input_request_i high for the caller to manage.
  task automatic read_check(input logic [7:0] a1, input logic [7:0] a2);
    input_request_i = 1'b1;
    input_addr_i_1  = a1;
    input_addr_i_2  = a2;
    step();
    vectors++;
    if (input_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL rd_valid got %0b exp 1", input_valid_o);
    end
    vectors++;
    if (input_data_o_1 !== exp_rd(a1)) begin
      errors++;
      $display("FAIL rd_port1 addr %02h got %h exp %h", a1, input_data_o_1, exp_rd(a1));
    end
    vectors++;
    if (input_data_o_2 !== exp_rd(a2)) begin
      errors++;
      $display("FAIL rd_port2 addr %02h got %h exp %h", a2, input_data_o_2, exp_rd(a2));
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    vectors++;
    if (load_ready_o !== 1'b0 || load_done_o !== 1'b0 || busy_o !== 1'b0 ||
        input_valid_o !== 1'b0 || input_data_o_1 !== '0 || input_data_o_2 !== '0) begin
      errors++;
      $display("FAIL reset_state got rdy=%0b done=%0b busy=%0b vld=%0b exp all 0",
               load_ready_o, load_done_o, busy_o, input_valid_o);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic_burst();
    do_load(8'd0, 8'd2, 0, 1'b1);
    read_check(8'd0, 8'd1);
    vectors++;
    if (input_data_o_1[511:448] !== 64'h0 || input_data_o_1[63:0] !== 64'h0707070707070707 ||
        input_data_o_2[511:448] !== 64'h0808080808080808) begin
      errors++;
      $display("FAIL basic_slices got %h %h %h exp 0 0707.. 0808..",
               input_data_o_1[511:448], input_data_o_1[63:0], input_data_o_2[511:448]);
    end
    input_request_i = 1'b0;
    step();
    vectors++;
    if (input_valid_o !== 1'b0 || input_data_o_1 !== '0 || input_data_o_2 !== '0) begin
      errors++;
      $display("FAIL rd_idle got vld=%0b exp 0 with zero data", input_valid_o);
    end
  endtask

  task automatic test_stream();
    do_load(8'd0, 8'd5, 1, 1'b0);
    read_check(8'd0, 8'd1);
    read_check(8'd2, 8'd3);
    read_check(8'd4, 8'hFF);
    input_request_i = 1'b0;
    step();
    vectors++;
    if (input_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL stream_end_valid got %0b exp 0", input_valid_o);
    end
  endtask

  task automatic test_wrap();
    do_load(8'd254, 8'd3, 0, 1'b0);
    read_check(8'd254, 8'd0);
    read_check(8'hFF, 8'd254);
    input_request_i = 1'b0;
    step();
  endtask

  task automatic test_gaps();
    do_load(8'd20, 8'd1, 2, 1'b0);
    do_load(8'd21, 8'd2, 1, 1'b0);
    read_check(8'd20, 8'd21);
    read_check(8'd22, 8'd20);
    input_request_i = 1'b0;
    step();
  endtask

  task automatic test_collision();
    logic [511:0] old_line;
    logic [511:0] new_line;
    logic [63:0]  beat;
    old_line = exp_mem[5];
    load_start_i = 1'b1;
    load_base_i  = 8'd5;
    load_lines_i = 8'd1;
    step();
    load_start_i = 1'b0;
    new_line = '0;
    for (int k = 0; k < 8; k++) begin
      beat = {$urandom, $urandom};
      new_line[511 - 64 * k -: 64] = beat;
      load_valid_i = 1'b1;
      load_data_i  = beat;
      if (k == 7) begin
        input_request_i = 1'b1;
        input_addr_i_1  = 8'd5;
        input_addr_i_2  = 8'd5;
      end
      step();
    end
    load_valid_i = 1'b0;
    vectors++;
    if (input_valid_o !== 1'b1 || input_data_o_1 !== old_line || input_data_o_2 !== old_line) begin
      errors++;
      $display("FAIL collide_old got vld=%0b %h exp %h", input_valid_o, input_data_o_1, old_line);
    end
    vectors++;
    if (load_done_o !== 1'b1) begin
      errors++;
      $display("FAIL collide_done got %0b exp 1", load_done_o);
    end
    exp_mem[5] = new_line;
    step();
    vectors++;
    if (input_data_o_1 !== new_line || input_data_o_2 !== new_line) begin
      errors++;
      $display("FAIL collide_new got %h exp %h", input_data_o_1, new_line);
    end
    input_request_i = 1'b0;
    step();
  endtask

  task automatic test_abort_reset();
    load_start_i = 1'b1;
    load_base_i  = 8'd3;
    load_lines_i = 8'd2;
    step();
    load_start_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      load_valid_i = 1'b1;
      load_data_i  = {$urandom, $urandom};
      step();
    end
    reset           = 1'b1;
    load_data_i     = {$urandom, $urandom};
    input_request_i = 1'b1;
    input_addr_i_1  = 8'd3;
    input_addr_i_2  = 8'd3;
    step();
    reset           = 1'b0;
    load_valid_i    = 1'b0;
    input_request_i = 1'b0;
    vectors++;
    if (busy_o !== 1'b0 || load_ready_o !== 1'b0 || input_valid_o !== 1'b0 || load_done_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_state got busy=%0b rdy=%0b vld=%0b done=%0b exp 0",
               busy_o, load_ready_o, input_valid_o, load_done_o);
    end
    step();
    read_check(8'd3, 8'd4);
    input_request_i = 1'b0;
    step();
  endtask

  task automatic test_zero_lines();
    load_start_i = 1'b1;
    load_base_i  = 8'd9;
    load_lines_i = 8'd0;
    step();
    load_start_i = 1'b0;
    vectors++;
    if (busy_o !== 1'b0 || load_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL zero_lines_busy got busy=%0b rdy=%0b exp 0", busy_o, load_ready_o);
    end
    step();
    vectors++;
    if (load_done_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL zero_lines_done got done=%0b busy=%0b exp 0", load_done_o, busy_o);
    end
  endtask

  task automatic test_random_reads();
    logic [7:0] pool[$];
    logic [7:0] a1, a2;
    bit         req;
    for (int i = 0; i < 256; i++) if (known[i]) pool.push_back(8'(i));
    pool.push_back(8'hFF);
    for (int n = 0; n < 40; n++) begin
      req = ($urandom_range(0, 3) != 0);
      a1  = pool[$urandom_range(0, pool.size() - 1)];
      a2  = pool[$urandom_range(0, pool.size() - 1)];
      if (req) begin
        read_check(a1, a2);
      end else begin
        input_request_i = 1'b0;
        input_addr_i_1  = a1;
        input_addr_i_2  = a2;
        step();
        vectors++;
        if (input_valid_o !== 1'b0 || input_data_o_1 !== '0 || input_data_o_2 !== '0) begin
          errors++;
          $display("FAIL rand_idle got vld=%0b exp 0 with zero data", input_valid_o);
        end
      end
    end
    input_request_i = 1'b0;
    step();
  endtask

  initial begin
    reset           = 1'b1;
    load_start_i    = 1'b0;
    load_base_i     = '0;
    load_lines_i    = '0;
    load_valid_i    = 1'b0;
    load_data_i     = '0;
    input_addr_i_1  = '0;
    input_addr_i_2  = '0;
    input_request_i = 1'b0;
    for (int i = 0; i < 256; i++) begin
      exp_mem[i] = '0;
      known[i]   = 1'b0;
    end

    test_reset();
    test_basic_burst();
    test_stream();
    test_wrap();
    test_gaps();
    test_collision();
    test_abort_reset();
    test_zero_lines();
    do_load(8'($urandom_range(30, 200)), 8'($urandom_range(1, 4)), 1, 1'b0);
    test_random_reads();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got no finish exp finish");
    $fatal(1, "timeout");
  end

endmodule
